muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the CPU's MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO instructions.
- Sits directly downstream of the register file and consumes its two read ports (Rs, Rt) as operands.
- Owns the HI/LO registers. Their values return to the register file write port through the write-back mux on MFHI/MFLO.
- Raises a stall so the datapath holds PC and operands while an operation runs.

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_unit_div_iter.sv | 53 +++++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings used on the op port
//   - FSM state encodings
//   - default iteration count (one iteration per operand bit)
package muldiv_unit_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring-divider step datapath working on unsigned magnitudes.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            capture dividend/divisor and clear the partial remainder
//   step            perform one restoring-division step
//   dividend        unsigned dividend (captured on load)
//   divisor         unsigned divisor (captured on load)
//   quotient        quotient after WIDTH steps
//   remainder       remainder after WIDTH steps
// A zero divisor needs no special case: every step "succeeds", giving an
// all-ones quotient and the dividend as remainder.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH:0]   shifted;
    logic             fits;

    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, div_r});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r <= '0;
            quo_r <= '0;
            div_r <= '0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dividend;
            div_r <= divisor;
        end else if (step) begin
            // The true difference is below 2^WIDTH, so the low bits suffice.
            rem_r <= fits ? (shifted[WIDTH-1:0] - div_r) : shifted[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], fits};
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst          clock, async active-high reset
//   ena               unit enable; 0 freezes all state
//   start, op         request MULTU/MULT/DIVU/DIV (sampled in IDLE only)
//   rs_data, rt_data  operands A and B from the register file
//   wr_hi, wr_lo      MTHI/MTLO strobes, wdata their data
//   hi, lo            HI/LO registers
//   busy              operation iterating
//   done              one-cycle pulse in the cycle HI/LO are loaded
//   stall             hold the datapath (new start accepted, or busy)
//
// state  | meaning
// IDLE   | waiting; accepts start or MTHI/MTLO writes
// RUN    | one multiply/divide iteration per enabled cycle
// FIN    | sign fix-up, HI/LO load, done pulse
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = muldiv_unit_pkg::ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(ITER);

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_r;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               in_signed;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign accept    = start & ena & (state == S_IDLE);
    assign in_signed = op_is_signed(op);

    // Two's-complement negation of 0x80000000 yields 0x80000000, which is
    // the correct magnitude when read as unsigned.
    assign mag_a_in = (in_signed & rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign mag_b_in = (in_signed & rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign acc_step = {add_sum, acc[WIDTH-1:1]};

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (ena & (state == S_RUN) & is_div_r),
        .dividend  (mag_a_in),
        .divisor   (mag_b_in),
        .quotient  (quo),
        .remainder (rem)
    );

    // Unsigned ops store both signs as 0, so no fix-up is applied to them.
    assign prod   = (sign_a ^ sign_b) ? -acc : acc;
    assign q_fix  = (sign_a ^ sign_b) ? -quo : quo;
    assign r_fix  = sign_a ? -rem : rem;
    assign res_hi = is_div_r ? r_fix : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div_r ? q_fix : prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ena) begin
            case (state)
                S_IDLE:  if (start) state_nx = S_RUN;
                S_RUN:   if (cnt == CNT_W'(ITER - 1)) state_nx = S_FIN;
                S_FIN:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div_r <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= '0;
            acc      <= '0;
        end else if (ena) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div_r <= op_is_div(op);
                        sign_a   <= in_signed & rs_data[WIDTH-1];
                        sign_b   <= in_signed & rt_data[WIDTH-1];
                        mag_a    <= mag_a_in;
                        acc      <= {{WIDTH{1'b0}}, mag_b_in};
                        cnt      <= '0;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!is_div_r) acc <= acc_step;
                end
                S_FIN: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == S_RUN);
    assign done  = ena & (state == S_FIN);
    assign stall = accept | busy;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    // Reference: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub;
        longint sa, sb, q, r;
        logic [63:0] res;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            OP_MULTU: res = ua * ub;
            OP_MULT:  res = sa * sb;
            OP_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default: begin
                if (b == 0) res = {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Launches one op and follows it until the cycle after done (HI/LO visible).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int pause_at, input int pause_len, input int poke_at,
                          input logic wr_with_start,
                          output int lat, output logic [63:0] btrace, output logic [63:0] dtrace,
                          output logic [31:0] hi_mid, output logic [31:0] lo_mid,
                          output logic stall0);
        btrace = '0;
        dtrace = '0;
        hi_mid = '0;
        lo_mid = '0;
        lat = -1;
        ena = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        start = 1'b1;
        wr_hi = wr_with_start;
        wr_lo = wr_with_start;
        wdata = $urandom;
        #1 stall0 = stall;
        for (int n = 1; n < 64; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            wr_hi = 1'b0;
            wr_lo = 1'b0;
            ena = !(n >= pause_at && n < pause_at + pause_len);
            if (n == poke_at) begin
                start = 1'b1;
                wr_hi = 1'b1;
                wr_lo = 1'b1;
                wdata = $urandom;
                rs_data = $urandom;
                rt_data = $urandom;
            end
            #1;
            btrace[n] = busy;
            dtrace[n] = done;
            if (n == 2) begin
                hi_mid = hi;
                lo_mid = lo;
            end
            if (done && lat < 0) lat = n;
            if (lat >= 0 && n == lat + 1) break;
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        ena = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_cycle();
        step_cycle();
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got hi=%h lo=%h, want 0/0", hi, lo);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b stall=%b, want 000", busy, done, stall);
        end
        rst = 1'b0;
        ena = 1'b1;
        step_cycle();
    endtask

    task automatic test_multu_timing();
        int lat;
        logic [63:0] bt, dt;
        logic [31:0] hm, lm;
        logic s0;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, 0, -1, 1'b0, lat, bt, dt, hm, lm, s0);
        checks++;
        if (s0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_on_start: got %b want 1", s0);
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL multu_latency: got %0d want 33", lat);
        end
        for (int n = 1; n <= 34; n++) begin
            checks++;
            if (bt[n] !== (n <= 32) || dt[n] !== (n == 33)) begin
                errors++;
                $display("FAIL multu_trace cycle T+%0d: got busy=%b done=%b want busy=%b done=%b",
                         n, bt[n], dt[n], (n <= 32), (n == 33));
            end
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max: got hi=%h lo=%h want fffffffe/00000001", hi, lo);
        end
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'h0000_0001;
    endtask

    task automatic test_directed();
        logic [1:0]  d_op [9] = '{OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_MULT, OP_DIV};
        logic [31:0] d_a  [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB,
                                  32'd5, 32'd100, 32'h8000_0000, 32'd7};
        logic [31:0] d_b  [9] = '{32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd7,
                                  32'h8000_0000, 32'hFFFF_FFFE};
        logic [31:0] d_hi [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFFB,
                                  32'd5, 32'd2, 32'h4000_0000, 32'd1};
        logic [31:0] d_lo [9] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h0000_0001, 32'hFFFF_FFFF, 32'd14, 32'd0, 32'hFFFF_FFFD};
        int lat;
        logic [63:0] bt, dt;
        logic [31:0] hm, lm;
        logic s0;
        for (int i = 0; i < 9; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], -10, 0, -1, 1'b0, lat, bt, dt, hm, lm, s0);
            checks++;
            if (lat !== 33 || hi !== d_hi[i] || lo !== d_lo[i]) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h want lat=33 hi=%h lo=%h",
                         i, d_op[i], d_a[i], d_b[i], lat, hi, lo, d_hi[i], d_lo[i]);
            end
            exp_hi = d_hi[i];
            exp_lo = d_lo[i];
        end
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        logic [63:0] bt, dt, ref_v;
        logic [31:0] hm, lm, a, b;
        logic s0;
        wr_hi = 1'b1;
        wdata = 32'h1234_5678;
        step_cycle();
        wr_hi = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== exp_lo) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h want %h/%h", hi, lo, 32'h1234_5678, exp_lo);
        end
        exp_hi = 32'h1234_5678;
        wr_lo = 1'b1;
        wdata = 32'h9ABC_DEF0;
        step_cycle();
        wr_lo = 1'b0;
        #1;
        checks++;
        if (lo !== 32'h9ABC_DEF0 || hi !== exp_hi) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h want %h/%h", hi, lo, exp_hi, 32'h9ABC_DEF0);
        end
        exp_lo = 32'h9ABC_DEF0;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'h0F0F_0F0F;
        step_cycle();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL mthi_mtlo_same_cycle: got hi=%h lo=%h want 0f0f0f0f/0f0f0f0f", hi, lo);
        end
        exp_hi = 32'h0F0F_0F0F;
        exp_lo = 32'h0F0F_0F0F;

        // Writes during RUN must be dropped.
        a = $urandom;
        b = $urandom;
        ref_v = model(OP_MULTU, a, b);
        run_op(OP_MULTU, a, b, -10, 0, 1, 1'b0, lat, bt, dt, hm, lm, s0);
        checks++;
        if (hm !== exp_hi || lm !== exp_lo) begin
            errors++;
            $display("FAIL write_during_run: got hi=%h lo=%h want %h/%h", hm, lm, exp_hi, exp_lo);
        end
        checks++;
        if (lat !== 33 || hi !== ref_v[63:32] || lo !== ref_v[31:0]) begin
            errors++;
            $display("FAIL run_after_write: got lat=%0d hi=%h lo=%h want 33 %h/%h", lat, hi, lo, ref_v[63:32], ref_v[31:0]);
        end
        exp_hi = ref_v[63:32];
        exp_lo = ref_v[31:0];

        // start and writes in the same IDLE cycle: start wins.
        a = $urandom;
        b = $urandom;
        ref_v = model(OP_DIVU, a, b);
        run_op(OP_DIVU, a, b, -10, 0, -1, 1'b1, lat, bt, dt, hm, lm, s0);
        checks++;
        if (hm !== exp_hi || lm !== exp_lo) begin
            errors++;
            $display("FAIL write_with_start: got hi=%h lo=%h want %h/%h", hm, lm, exp_hi, exp_lo);
        end
        checks++;
        if (lat !== 33 || hi !== ref_v[63:32] || lo !== ref_v[31:0]) begin
            errors++;
            $display("FAIL op_with_write: got lat=%0d hi=%h lo=%h want 33 %h/%h", lat, hi, lo, ref_v[63:32], ref_v[31:0]);
        end
        exp_hi = ref_v[63:32];
        exp_lo = ref_v[31:0];
    endtask

    task automatic test_reset_mid_op();
        int lat, pulses;
        logic [63:0] bt, dt;
        logic [31:0] hm, lm;
        logic s0;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hDEAD_BEEF;
        step_cycle();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        op = OP_MULTU;
        rs_data = 32'd2;
        rt_data = 32'd3;
        start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step_cycle();
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
        end
        step_cycle();
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            step_cycle();
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL no_done_after_abort: got %0d pulses want 0", pulses);
        end
        run_op(OP_MULTU, 32'd2, 32'd3, -10, 0, -1, 1'b0, lat, bt, dt, hm, lm, s0);
        checks++;
        if (lat !== 33 || hi !== 32'd0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL op_after_reset: got lat=%0d hi=%h lo=%h want 33 0/6", lat, hi, lo);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd6;
    endtask

    task automatic test_ena_hold();
        int lat, pulses;
        logic [63:0] bt, dt, ref_v;
        logic [31:0] hm, lm;
        logic s0;
        ref_v = model(OP_MULT, 32'hFFFF_FFF6, 32'd12345);
        run_op(OP_MULT, 32'hFFFF_FFF6, 32'd12345, 10, 5, 20, 1'b0, lat, bt, dt, hm, lm, s0);
        checks++;
        if (lat !== 38) begin
            errors++;
            $display("FAIL ena_latency: got %0d want 38", lat);
        end
        checks++;
        if (bt[37] !== 1'b1 || bt[38] !== 1'b0) begin
            errors++;
            $display("FAIL ena_busy: got busy@37=%b busy@38=%b want 1/0", bt[37], bt[38]);
        end
        checks++;
        if (hi !== ref_v[63:32] || lo !== ref_v[31:0]) begin
            errors++;
            $display("FAIL ena_result: got hi=%h lo=%h want %h/%h", hi, lo, ref_v[63:32], ref_v[31:0]);
        end
        exp_hi = ref_v[63:32];
        exp_lo = ref_v[31:0];
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            step_cycle();
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL start_while_busy_ignored: got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [63:0] bt, dt, ref_v;
        logic [31:0] hm, lm, a, b;
        logic [1:0] o;
        logic s0;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            ref_v = model(o, a, b);
            run_op(o, a, b, -10, 0, -1, 1'b0, lat, bt, dt, hm, lm, s0);
            checks++;
            if (lat !== 33 || hi !== ref_v[63:32] || lo !== ref_v[31:0]) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h want 33 %h/%h",
                         i, o, a, b, lat, hi, lo, ref_v[63:32], ref_v[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_timing();
        test_directed();
        test_mthi_mtlo();
        test_reset_mid_op();
        test_ena_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
